// File: rtl/clocken_if.sv
// clocken_if: bundle of the divided-clock enable strobes and observation clock
`timescale 1ns/1ps
interface clocken_if;
  logic clken;
  logic clken2;
  logic slowclk;
  modport master (output clken, output clken2, output slowclk);
  modport slave (input clken, input clken2, input slowclk);
endinterface

// File: rtl/clocken.sv
// clocken: divides sysclk by DIVISOR into clken/clken2 strobes and a 50% slowclk
`timescale 1ns/1ps
module clocken #(
  parameter int DIVISOR = 8,
  parameter int CW = $clog2(DIVISOR)
) (
  input logic sysclk,
  input logic rst_n,
  clocken_if.master out_if
);
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] MID_M1 = CW'(DIVISOR / 2 - 1);
  localparam logic [CW-1:0] MID = CW'(DIVISOR / 2);
  if (DIVISOR < 4 || DIVISOR % 2 != 0) begin : g_bad_divisor
    $error("clocken: DIVISOR must be an even integer >= 4");
  end
  logic [CW-1:0] cnt_q, cnt_d;
  logic clken_q, clken2_q, slowclk_q;
  always_comb cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  // outputs decode the next count so they line up with cnt_q without a comb path
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      clken_q <= 1'b0;
      clken2_q <= 1'b0;
      slowclk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clken_q <= (cnt_d == LAST);
      clken2_q <= (cnt_d == MID_M1);
      slowclk_q <= (cnt_d >= MID);
    end
  end
  assign out_if.clken = clken_q;
  assign out_if.clken2 = clken2_q;
  assign out_if.slowclk = slowclk_q;
endmodule

// File: tb/tb_clocken.sv
// tb_clocken: directed checks of clocken at DIVISOR 4, 8 and 16 against hand-written phase tables
`timescale 1ns/1ps
module tb_clocken;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int k = 0;
  clocken_if i4();
  clocken_if i8();
  clocken_if i16();
  clocken #(.DIVISOR(4)) u4 (.sysclk(clk), .rst_n(rst_n), .out_if(i4));
  clocken #(.DIVISOR(8)) u8 (.sysclk(clk), .rst_n(rst_n), .out_if(i8));
  clocken #(.DIVISOR(16)) u16 (.sysclk(clk), .rst_n(rst_n), .out_if(i16));
  always #1 clk = ~clk;
  logic [3:0] t4_ce = 4'b1000, t4_ce2 = 4'b0010, t4_sl = 4'b1100;
  logic [7:0] t8_ce = 8'b1000_0000, t8_ce2 = 8'b0000_1000, t8_sl = 8'b1111_0000;
  logic [15:0] t16_ce = 16'h8000, t16_ce2 = 16'h0080, t16_sl = 16'hFF00;
  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " d4.clken"}, i4.clken, 1'b0);
    chk({tag, " d4.clken2"}, i4.clken2, 1'b0);
    chk({tag, " d4.slowclk"}, i4.slowclk, 1'b0);
    chk({tag, " d8.clken"}, i8.clken, 1'b0);
    chk({tag, " d8.clken2"}, i8.clken2, 1'b0);
    chk({tag, " d8.slowclk"}, i8.slowclk, 1'b0);
    chk({tag, " d16.clken"}, i16.clken, 1'b0);
    chk({tag, " d16.clken2"}, i16.clken2, 1'b0);
    chk({tag, " d16.slowclk"}, i16.slowclk, 1'b0);
  endtask
  task automatic run_edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      k++;
      chk("d4.clken", i4.clken, t4_ce[k % 4]);
      chk("d4.clken2", i4.clken2, t4_ce2[k % 4]);
      chk("d4.slowclk", i4.slowclk, t4_sl[k % 4]);
      chk("d8.clken", i8.clken, t8_ce[k % 8]);
      chk("d8.clken2", i8.clken2, t8_ce2[k % 8]);
      chk("d8.slowclk", i8.slowclk, t8_sl[k % 8]);
      chk("d16.clken", i16.clken, t16_ce[k % 16]);
      chk("d16.clken2", i16.clken2, t16_ce2[k % 16]);
      chk("d16.slowclk", i16.slowclk, t16_sl[k % 16]);
    end
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_zero("reset_hold");
    end
    rst_n = 1'b1;
    k = 0;
    run_edges(16 * 13);
    run_edges(5);
    chk("mid d8.slowclk_before_reset", i8.slowclk, 1'b1);
    #0.5;
    rst_n = 1'b0;
    #0.2;
    chk_zero("async_reset");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_zero("reset_hold2");
    end
    rst_n = 1'b1;
    k = 0;
    run_edges(40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
